// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - two-port (CPU / loader) arbiter in front of a single SDRAM controller
// Fixed priority to port A, with a burst limit so a continuously busy CPU cannot starve port B.

module sdram_port_arbiter #(
   parameter int BURST_MAX = 4,
   parameter int TIMEOUT   = 255
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        a_req,
   input  logic        a_we,
   input  logic [22:0] a_addr,
   input  logic [7:0]  a_din,
   output logic        a_ack,
   output logic [7:0]  a_dout,
   input  logic        b_req,
   input  logic        b_we,
   input  logic [22:0] b_addr,
   input  logic [7:0]  b_din,
   output logic        b_ack,
   output logic [7:0]  b_dout,
   output logic [22:0] sdram_a,
   output logic [7:0]  sdram_in,
   output logic        sdram_we,
   output logic        sdram_rd,
   input  logic [7:0]  sdram_out,
   input  logic        sdram_ready,
   output logic        timeout_err
);

   localparam int BW = (BURST_MAX < 1) ? 1 : $clog2(BURST_MAX + 1);
   localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [BW-1:0] BURST_LAST = BW'(BURST_MAX);
   localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_DONE
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic            r_sel_b;
   logic            r_we;
   logic [22:0]     r_addr;
   logic [7:0]      r_din;
   logic [7:0]      r_a_dout;
   logic [7:0]      r_b_dout;
   logic [BW-1:0]   r_burst_cnt;
   logic [WW-1:0]   r_wait_cnt;
   logic            r_timeout_err;
   logic            w_grant;
   logic            w_pick_b;
   logic            w_timeout;

   // B only overtakes A once A has used up its burst allowance.
   assign w_pick_b  = b_req && (!a_req || (r_burst_cnt == BURST_LAST));
   assign w_grant   = (r_state == ST_IDLE) && (a_req || b_req);
   assign w_timeout = (r_state == ST_WAIT) && !sdram_ready && (r_wait_cnt == WAIT_LAST);

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (a_req || b_req) w_state_nxt = ST_ISSUE;
         ST_ISSUE: w_state_nxt = ST_WAIT;
         ST_WAIT:  if (sdram_ready || w_timeout) w_state_nxt = ST_DONE;
         ST_DONE:  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_sel_b       <= 1'b0;
         r_we          <= 1'b0;
         r_addr        <= '0;
         r_din         <= '0;
         r_a_dout      <= '0;
         r_b_dout      <= '0;
         r_burst_cnt   <= '0;
         r_wait_cnt    <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         if (w_grant) begin
            r_sel_b    <= w_pick_b;
            r_we       <= w_pick_b ? b_we   : a_we;
            r_addr     <= w_pick_b ? b_addr : a_addr;
            r_din      <= w_pick_b ? b_din  : a_din;
            r_wait_cnt <= '0;
            if (w_pick_b || !b_req) begin
               r_burst_cnt <= '0;
            end else if (r_burst_cnt != BURST_LAST) begin
               r_burst_cnt <= r_burst_cnt + BW'(1);
            end
         end
         if (r_state == ST_WAIT) begin
            r_wait_cnt <= r_wait_cnt + WW'(1);
            if (sdram_ready && !r_we) begin
               if (r_sel_b) begin
                  r_b_dout <= sdram_out;
               end else begin
                  r_a_dout <= sdram_out;
               end
            end
         end
         if (w_timeout) begin
            r_timeout_err <= 1'b1;
         end
      end
   end

   assign sdram_we    = (r_state == ST_ISSUE) && r_we;
   assign sdram_rd    = (r_state == ST_ISSUE) && !r_we;
   assign a_ack       = (r_state == ST_DONE) && !r_sel_b;
   assign b_ack       = (r_state == ST_DONE) && r_sel_b;
   assign sdram_a     = r_addr;
   assign sdram_in    = r_din;
   assign a_dout      = r_a_dout;
   assign b_dout      = r_b_dout;
   assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - directed self-checking bench for sdram_port_arbiter
// Inputs change and outputs are sampled 1 time unit after each rising edge.

module tb_sdram_port_arbiter;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic        a_req, a_we, b_req, b_we;
   logic [22:0] a_addr, b_addr;
   logic [7:0]  a_din, b_din;
   logic        a_ack, b_ack;
   logic [7:0]  a_dout, b_dout;
   logic [22:0] sdram_a;
   logic [7:0]  sdram_in;
   logic        sdram_we, sdram_rd;
   logic [7:0]  sdram_out;
   logic        sdram_ready;
   logic        timeout_err;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk_sys = ~clk_sys;

   sdram_port_arbiter #(.BURST_MAX(4), .TIMEOUT(8)) dut (
      .clk_sys(clk_sys), .reset(reset),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
      .a_ack(a_ack), .a_dout(a_dout),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_din(b_din),
      .b_ack(b_ack), .b_dout(b_dout),
      .sdram_a(sdram_a), .sdram_in(sdram_in), .sdram_we(sdram_we), .sdram_rd(sdram_rd),
      .sdram_out(sdram_out), .sdram_ready(sdram_ready), .timeout_err(timeout_err)
   );

   task automatic tick;
      @(posedge clk_sys);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      tick();
      tick();
      n_cmp++;
      if ({a_ack, b_ack, sdram_we, sdram_rd, timeout_err} !== 5'b0) begin
         n_err++;
         $display("FAIL reset_ctl: got %b want 00000", {a_ack, b_ack, sdram_we, sdram_rd, timeout_err});
      end
      n_cmp++;
      if ({a_dout, b_dout, sdram_a, sdram_in} !== 47'h0) begin
         n_err++;
         $display("FAIL reset_data: got %h want 0", {a_dout, b_dout, sdram_a, sdram_in});
      end
      reset = 1'b0;
   endtask

   task automatic test_a_read;
      a_req = 1'b1; a_we = 1'b0; a_addr = 23'h000123;
      tick();
      n_cmp++;
      if ({sdram_rd, sdram_we, a_ack, sdram_a} !== {3'b100, 23'h000123}) begin
         n_err++;
         $display("FAIL a_read_issue: got rd/we/ack=%b%b%b addr=%h want 100 000123", sdram_rd, sdram_we, a_ack, sdram_a);
      end
      sdram_ready = 1'b1; sdram_out = 8'h5A;
      tick();
      n_cmp++;
      if ({sdram_rd, a_ack} !== 2'b00) begin
         n_err++;
         $display("FAIL a_read_wait: got rd/ack=%b%b want 00", sdram_rd, a_ack);
      end
      tick();
      n_cmp++;
      if ({a_ack, b_ack, a_dout} !== {2'b10, 8'h5A}) begin
         n_err++;
         $display("FAIL a_read_done: got ack=%b%b dout=%h want 10 5a", a_ack, b_ack, a_dout);
      end
      a_req = 1'b0; sdram_ready = 1'b0;
      tick();
      n_cmp++;
      if ({a_ack, sdram_rd, sdram_a} !== {2'b00, 23'h000123}) begin
         n_err++;
         $display("FAIL a_read_idle: got ack/rd=%b%b addr=%h want 00 000123", a_ack, sdram_rd, sdram_a);
      end
   endtask

   task automatic test_b_write;
      b_req = 1'b1; b_we = 1'b1; b_addr = 23'h400000; b_din = 8'hC3;
      tick();
      n_cmp++;
      if ({sdram_we, sdram_rd, sdram_in, sdram_a} !== {2'b10, 8'hC3, 23'h400000}) begin
         n_err++;
         $display("FAIL b_write_issue: got we/rd=%b%b din=%h addr=%h want 10 c3 400000", sdram_we, sdram_rd, sdram_in, sdram_a);
      end
      sdram_ready = 1'b1; sdram_out = 8'h77;
      tick();
      tick();
      n_cmp++;
      if ({b_ack, a_ack, b_dout} !== {2'b10, 8'h00}) begin
         n_err++;
         $display("FAIL b_write_done: got ack b/a=%b%b dout=%h want 10 00", b_ack, a_ack, b_dout);
      end
      b_req = 1'b0; sdram_ready = 1'b0;
      tick();
      n_cmp++;
      if ({b_ack, sdram_we} !== 2'b00) begin
         n_err++;
         $display("FAIL b_write_idle: got ack/we=%b%b want 00", b_ack, sdram_we);
      end
   endtask

   task automatic test_contention;
      string exp_seq;
      byte   got;
      int    k;
      exp_seq = "AAAABAAAAB";
      k = 0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      a_req = 1'b1; a_we = 1'b0; a_addr = 23'h000010;
      b_req = 1'b1; b_we = 1'b0; b_addr = 23'h000020;
      sdram_ready = 1'b1; sdram_out = 8'h3C;
      for (int c = 0; c < 80 && k < 10; c++) begin
         tick();
         if (a_ack && b_ack) begin
            n_cmp++;
            n_err++;
            $display("FAIL dual_ack: both acks at cycle %0d", c);
         end
         if (a_ack || b_ack) begin
            got = a_ack ? "A" : "B";
            n_cmp++;
            if (got !== exp_seq[k]) begin
               n_err++;
               $display("FAIL contention_ack%0d: got %c want %c", k, got, exp_seq[k]);
            end
            k++;
         end
      end
      a_req = 1'b0; b_req = 1'b0; sdram_ready = 1'b0;
      n_cmp++;
      if (k !== 10) begin
         n_err++;
         $display("FAIL contention_count: got %0d acks want 10", k);
      end
      tick();
      n_cmp++;
      if ({a_dout, b_dout} !== 16'h3C3C) begin
         n_err++;
         $display("FAIL contention_dout: got %h want 3c3c", {a_dout, b_dout});
      end
   endtask

   task automatic test_timeout;
      int n;
      a_req = 1'b1; a_we = 1'b0; a_addr = 23'h000055;
      tick();
      tick();
      n = 0;
      while (n < 30) begin
         tick();
         n++;
         if (a_ack) break;
      end
      n_cmp++;
      if (n !== 8) begin
         n_err++;
         $display("FAIL timeout_latency: got %0d cycles want 8", n);
      end
      n_cmp++;
      if ({timeout_err, a_dout} !== {1'b1, 8'h3C}) begin
         n_err++;
         $display("FAIL timeout_flag: got err=%b dout=%h want 1 3c", timeout_err, a_dout);
      end
      a_req = 1'b0;
      tick();
      a_req = 1'b1; a_we = 1'b1; a_addr = 23'h000066; a_din = 8'hE7;
      tick();
      n_cmp++;
      if ({sdram_we, sdram_in, sdram_a} !== {1'b1, 8'hE7, 23'h000066}) begin
         n_err++;
         $display("FAIL post_timeout_issue: got we=%b din=%h addr=%h want 1 e7 000066", sdram_we, sdram_in, sdram_a);
      end
      a_req = 1'b0; sdram_ready = 1'b1;
      tick();
      tick();
      n_cmp++;
      if ({a_ack, timeout_err, a_dout} !== {2'b11, 8'h3C}) begin
         n_err++;
         $display("FAIL post_timeout_done: got ack=%b err=%b dout=%h want 1 1 3c", a_ack, timeout_err, a_dout);
      end
      sdram_ready = 1'b0;
      tick();
   endtask

   task automatic test_drop;
      int seen_b;
      seen_b = 0;
      a_req = 1'b1; a_we = 1'b0; a_addr = 23'h000077;
      tick();
      b_req = 1'b1; b_we = 1'b0;
      tick();
      b_req = 1'b0; sdram_ready = 1'b1; sdram_out = 8'h42;
      tick();
      n_cmp++;
      if ({a_ack, a_dout} !== {1'b1, 8'h42}) begin
         n_err++;
         $display("FAIL drop_a_done: got ack=%b dout=%h want 1 42", a_ack, a_dout);
      end
      a_req = 1'b0; sdram_ready = 1'b0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (b_ack || sdram_rd) seen_b++;
      end
      n_cmp++;
      if (seen_b !== 0) begin
         n_err++;
         $display("FAIL drop_b: got %0d activity cycles want 0", seen_b);
      end
   endtask

   task automatic test_reset_wait;
      a_req = 1'b1; a_we = 1'b0; a_addr = 23'h000099;
      tick();
      tick();
      b_req = 1'b1; b_we = 1'b0; b_addr = 23'h2AAAAA;
      reset = 1'b1;
      tick();
      reset = 1'b0; a_req = 1'b0;
      n_cmp++;
      if ({a_ack, b_ack, sdram_we, sdram_rd, timeout_err, a_dout, b_dout, sdram_a, sdram_in} !== 52'h0) begin
         n_err++;
         $display("FAIL reset_wait_outputs: got ack=%b%b we/rd=%b%b err=%b data=%h want all 0",
                  a_ack, b_ack, sdram_we, sdram_rd, timeout_err, {a_dout, b_dout, sdram_a, sdram_in});
      end
      tick();
      n_cmp++;
      if ({sdram_rd, sdram_a} !== {1'b1, 23'h2AAAAA}) begin
         n_err++;
         $display("FAIL reset_wait_b_issue: got rd=%b addr=%h want 1 2aaaaa", sdram_rd, sdram_a);
      end
      sdram_ready = 1'b1; sdram_out = 8'h11;
      tick();
      tick();
      n_cmp++;
      if ({b_ack, a_ack, b_dout} !== {2'b10, 8'h11}) begin
         n_err++;
         $display("FAIL reset_wait_b_done: got ack b/a=%b%b dout=%h want 10 11", b_ack, a_ack, b_dout);
      end
      b_req = 1'b0; sdram_ready = 1'b0;
      tick();
   endtask

   initial begin
      reset = 1'b1;
      a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_din = '0;
      b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_din = '0;
      sdram_out = '0; sdram_ready = 1'b0;
      test_reset();
      test_a_read();
      test_b_write();
      test_contention();
      test_timeout();
      test_drop();
      test_reset_wait();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sdram_port_arbiter.md
SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 SHALL have parameter BURST_MAX, default 4: maximum consecutive port-A grants while port B is pending.
REQ-002 SHALL have parameter TIMEOUT, default 255: cycles to wait for sdram_ready before aborting a transfer.
REQ-003 SHALL have port clk_sys, input, 1: sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have ports a_req, input, 1 and a_we, input, 1: port A (CPU) request level and write flag.
REQ-006 SHALL have ports a_addr, input, 23 and a_din, input, 8: port A address and write data.
REQ-007 SHALL have ports a_ack, output, 1 and a_dout, output, 8: port A completion pulse and read data.
REQ-008 SHALL have ports b_req, b_we, b_addr, b_din, b_ack and b_dout: port B (loader/DMA), with the same widths and meanings as the port A signals.
REQ-009 SHALL have ports sdram_a, output, 23; sdram_in, output, 8; sdram_we, output, 1; sdram_rd, output, 1: command to the SDRAM controller.
REQ-010 SHALL have ports sdram_out, input, 8 and sdram_ready, input, 1: controller read data and completion strobe.
REQ-011 SHALL have port timeout_err, output, 1: sticky flag, set on any aborted transfer.

Function
REQ-012 SHALL implement the states IDLE, ISSUE, WAIT and DONE.
REQ-013 In IDLE with any request pending, SHALL latch the grant, address, data and we of the winner, then go to ISSUE on the next edge.
REQ-014 Arbitration SHALL use fixed priority: A wins over B, except when burst_cnt == BURST_MAX and b_req=1, in which case B wins.
REQ-015 burst_cnt SHALL increment on each A grant made while b_req=1.
REQ-016 burst_cnt SHALL clear on any B grant, and on any A grant made while b_req=0.
REQ-017 burst_cnt SHALL saturate at BURST_MAX.
REQ-018 ISSUE SHALL last exactly 1 cycle.
REQ-019 During ISSUE, SHALL assert sdram_we (if we=1) or sdram_rd (if we=0) for that single cycle, then go to WAIT.
REQ-020 sdram_a and sdram_in SHALL hold the latched values from ISSUE until the next grant.
REQ-021 In WAIT, when sdram_ready=1, SHALL go to DONE.
REQ-022 For a read completing in WAIT, SHALL capture sdram_out into the granted port's dout.
REQ-023 In WAIT, SHALL increment a wait counter every cycle.
REQ-024 If the wait counter reaches TIMEOUT with sdram_ready still 0, SHALL set timeout_err, leave dout unchanged, and go to DONE.
REQ-025 In DONE, SHALL pulse the granted port's ack for exactly 1 cycle, then return to IDLE.
REQ-026 Each dout SHALL hold its value until that port's next completed read.
REQ-027 Minimum latency from req sampled in IDLE to ack SHALL be 4 cycles (IDLE → ISSUE → WAIT with sdram_ready=1 → DONE).
REQ-028 A requester SHALL hold req, addr, din and we stable until its ack; the arbiter latches inputs only at grant.
REQ-029 If a_req and b_req are first seen in the same IDLE cycle, A SHALL be granted, unless REQ-014 forces B.
REQ-030 sdram_ready asserted outside WAIT SHALL be ignored.
REQ-031 A request deasserted before its grant SHALL be dropped without an ack.
REQ-032 A request deasserted after its grant SHALL still complete, and its ack SHALL still be pulsed.
REQ-033 A requester still holding req after its ack SHALL be re-arbitrated in the next IDLE cycle as a new transfer.
REQ-034 At most one of sdram_we and sdram_rd SHALL be asserted in any cycle.
REQ-035 At most one of a_ack and b_ack SHALL be asserted in any cycle.

Reset
REQ-036 When reset=1 at a clock edge, SHALL enter IDLE and clear burst_cnt, the wait counter and timeout_err.
REQ-037 Reset SHALL drive a_ack, b_ack, sdram_we and sdram_rd to 0, and a_dout, b_dout, sdram_a and sdram_in to 0.
REQ-038 Reset asserted mid-transfer (ISSUE, WAIT or DONE) SHALL abort the transfer with no ack.
REQ-039 After reset, the first cycle with reset=0 SHALL be IDLE and able to grant.

Verification
REQ-040 Scenario A read: a_req=1, a_we=0, a_addr=23'h000123; sdram_ready on the 1st WAIT cycle with sdram_out=8'h5A -> sdram_rd pulsed once with sdram_a=23'h000123; a_ack on cycle 4; a_dout=8'h5A.
REQ-041 Scenario B write: b_req=1, b_we=1, b_addr=23'h400000, b_din=8'hC3 -> sdram_we pulsed once with sdram_in=8'hC3 and sdram_a=23'h400000; b_ack once; b_dout unchanged.
REQ-042 Scenario contention: a_req and b_req held continuously, BURST_MAX=4 -> ack sequence A,A,A,A,B,A,A,A,A,B,...
REQ-043 Scenario simultaneous first request: a_req and b_req rise in the same cycle after reset -> A is granted first.
REQ-044 Scenario timeout: TIMEOUT=8 and sdram_ready never asserted -> ack 8 WAIT cycles after WAIT entry, timeout_err=1, dout unchanged; the next transfer proceeds normally.
REQ-045 Scenario reset in WAIT: reset asserted for 1 cycle during WAIT of an A read -> no a_ack; all outputs 0; a pending b_req is granted on the first cycle after reset.
